// File: rtl/xbar_slave_scheduler_pkg.sv
// xbar_slave_scheduler_pkg: shared constants and types for the per-slave crossbar scheduler
package xbar_slave_scheduler_pkg;
  localparam int N_MASTERS = 4;
  localparam int ADDR_WIDTH = 32;
  localparam int DATA_WIDTH = 32;
  localparam int DEF_ORDER_DEPTH = 4;
  localparam int TIMEOUT_CYCLES = 16;
  typedef enum logic {IDLE, REQ} sched_state_e;
  typedef logic [$clog2(N_MASTERS)-1:0] master_id_t;
  function automatic logic [N_MASTERS-1:0] id_onehot(master_id_t id);
    return N_MASTERS'(1) << id;
  endfunction
endpackage

// File: rtl/xbar_slave_scheduler_id_fifo.sv
// xbar_id_fifo: in-order FIFO of master IDs for outstanding slave transactions
module xbar_id_fifo
  import xbar_slave_scheduler_pkg::*;
#(
  parameter int DEPTH = DEF_ORDER_DEPTH
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  master_id_t din_i,
  input  logic       pop_i,
  output master_id_t dout_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int PW = $clog2(DEPTH);
  master_id_t mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0] cnt_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= din_i;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_q + {{(PW-1){1'b0}}, push_i};
      rd_q  <= rd_q + {{(PW-1){1'b0}}, pop_i};
      cnt_q <= cnt_q + {{PW{1'b0}}, push_i} - {{PW{1'b0}}, pop_i};
    end
  assign dout_o  = mem_q[rd_q];
  assign full_o  = cnt_q == (PW+1)'(DEPTH);
  assign empty_o = cnt_q == '0;
endmodule

// File: rtl/xbar_slave_scheduler.sv
// xbar_slave_scheduler: round-robin share of one slave among masters with in-order response routing.
// Optional ack watchdog and m_err port when XBAR_SCHED_TIMEOUT_EN is defined.
module xbar_slave_scheduler
  import xbar_slave_scheduler_pkg::*;
#(
  parameter int ORDER_DEPTH = DEF_ORDER_DEPTH
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [N_MASTERS-1:0]            m_req,
  input  logic [N_MASTERS*ADDR_WIDTH-1:0] m_addr,
  input  logic [N_MASTERS-1:0]            m_cmd,
  input  logic [N_MASTERS*DATA_WIDTH-1:0] m_wdata,
  output logic [N_MASTERS-1:0]            m_ack,
  output logic [N_MASTERS-1:0]            m_resp,
  output logic [DATA_WIDTH-1:0]           m_rdata,
  output logic                            s_req,
  output logic [ADDR_WIDTH-1:0]           s_addr,
  output logic                            s_cmd,
  output logic [DATA_WIDTH-1:0]           s_wdata,
  input  logic                            s_ack,
  input  logic                            s_resp,
  input  logic [DATA_WIDTH-1:0]           s_rdata,
`ifdef XBAR_SCHED_TIMEOUT_EN
  output logic [N_MASTERS-1:0]            m_err,
`endif
  output logic                            busy,
  output logic                            spurious_resp
);
  sched_state_e state_q, state_d;
  master_id_t grant_q, grant_d, last_q, last_d, pick, head;
  logic full, empty, done, fire, pop, spurious_q;
  logic [N_MASTERS-1:0] grant_oh;
  // first requester after last_q wins: descending scan so the nearest offset is written last
  always_comb begin
    pick = '0;
    for (int i = N_MASTERS; i >= 1; i--) begin
      master_id_t idx;
      idx = master_id_t'((int'(last_q) + i) % N_MASTERS);
      if (m_req[idx]) pick = idx;
    end
  end
  assign grant_oh = id_onehot(grant_q);
  assign done     = state_q == REQ && s_ack;
  assign pop      = s_resp && !empty;
`ifdef XBAR_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) tmo_q <= '0;
    else tmo_q <= (state_q == REQ && !done && !fire) ? tmo_q + 1'b1 : '0;
  assign fire  = state_q == REQ && !s_ack && tmo_q == TW'(TIMEOUT_CYCLES);
  assign m_err = fire ? grant_oh : '0;
`else
  assign fire = 1'b0;
`endif
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    if (state_q == IDLE && |m_req && !full) begin
      state_d = REQ;
      grant_d = pick;
    end
    if (done || fire) begin
      state_d = IDLE;
      last_d  = grant_q;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      last_q     <= master_id_t'(N_MASTERS - 1);
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_q     <= last_d;
      spurious_q <= spurious_q | (s_resp && empty);
    end
  xbar_id_fifo #(.DEPTH(ORDER_DEPTH)) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (done),
    .din_i  (grant_q),
    .pop_i  (pop),
    .dout_o (head),
    .full_o (full),
    .empty_o(empty)
  );
  assign s_req         = state_q == REQ;
  assign s_addr        = s_req ? m_addr[grant_q*ADDR_WIDTH +: ADDR_WIDTH] : '0;
  assign s_wdata       = s_req ? m_wdata[grant_q*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign s_cmd         = s_req && m_cmd[grant_q];
  assign m_ack         = (done || fire) ? grant_oh : '0;
  assign m_resp        = pop ? id_onehot(head) : '0;
  assign m_rdata       = pop ? s_rdata : '0;
  assign busy          = s_req || !empty;
  assign spurious_resp = spurious_q;
endmodule

// File: tb/tb_xbar_slave_scheduler.sv
// tb_xbar_slave_scheduler: directed scoreboard bench for xbar_slave_scheduler
module tb_xbar_slave_scheduler;
  logic clk = 0, rst = 1;
  logic [3:0] m_req = 0, m_cmd = 0, m_ack, m_resp;
  logic [127:0] m_addr = 0, m_wdata = 0;
  logic [31:0] m_rdata, s_addr, s_wdata, s_rdata = 0;
  logic s_req, s_cmd, s_ack = 0, s_resp = 0, busy, spurious_resp;
`ifdef XBAR_SCHED_TIMEOUT_EN
  logic [3:0] m_err;
`endif
  int passed = 0, total = 0;
  int exp_own[$];

  always #5 clk = ~clk;

  xbar_slave_scheduler dut (
    .clk(clk), .rst(rst), .m_req(m_req), .m_addr(m_addr), .m_cmd(m_cmd), .m_wdata(m_wdata),
    .m_ack(m_ack), .m_resp(m_resp), .m_rdata(m_rdata), .s_req(s_req), .s_addr(s_addr),
    .s_cmd(s_cmd), .s_wdata(s_wdata), .s_ack(s_ack), .s_resp(s_resp), .s_rdata(s_rdata),
`ifdef XBAR_SCHED_TIMEOUT_EN
    .m_err(m_err),
`endif
    .busy(busy), .spurious_resp(spurious_resp)
  );

  function automatic logic [3:0] oh(int id);
    return 4'b0001 << id;
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic txn(logic [3:0] req, int id, bit with_resp, logic [31:0] rd);
    int n = 0;
    logic [3:0] want = 0;
    @(negedge clk);
    m_req = req; s_ack = 0; s_resp = 0; #1;
    while (!s_req && n < 20) begin @(negedge clk); #1; n++; end
    check("s_req_seen", s_req, 1);
    check("s_addr", s_addr, m_addr[id*32 +: 32]);
    check("s_wdata", s_wdata, m_wdata[id*32 +: 32]);
    check("s_cmd", s_cmd, m_cmd[id]);
    if (with_resp) begin
      s_resp = 1; s_rdata = rd;
      want = (exp_own.size() > 0) ? oh(exp_own.pop_front()) : 4'b0;
    end
    s_ack = 1; #1;
    check("m_ack", m_ack, oh(id));
    if (with_resp) begin
      check("m_resp_same_cycle", m_resp, want);
      check("m_rdata_same_cycle", m_rdata, rd);
    end
    exp_own.push_back(id);
  endtask

  task automatic resp(logic [31:0] rd);
    logic [3:0] want;
    @(negedge clk);
    s_ack = 0; s_resp = 1; s_rdata = rd;
    want = (exp_own.size() > 0) ? oh(exp_own.pop_front()) : 4'b0;
    #1;
    check("m_resp", m_resp, want);
    if (want != 0) check("m_rdata", m_rdata, rd);
  endtask

  task automatic release_bus();
    @(negedge clk);
    m_req = 0; s_ack = 0; s_resp = 0; #1;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_addr[i*32 +: 32]  = 32'h1000_0000 + 32'(i) * 32'h100;
      m_wdata[i*32 +: 32] = 32'h5000 + 32'(i);
    end
    m_cmd = 4'b1010;
    repeat (2) @(negedge clk);
    #1;
    check("rst_s_req", s_req, 0);
    check("rst_m_ack", m_ack, 0);
    check("rst_m_resp", m_resp, 0);
    check("rst_busy", busy, 0);
    check("rst_spurious", spurious_resp, 0);
    check("rst_s_addr", s_addr, 0);
    @(negedge clk); rst = 0;
    // round robin 0,1,2,3 fills the FIFO; grant then blocks until a response frees a slot
    txn(4'b1111, 0, 0, 0);
    @(negedge clk); s_ack = 0; #1;
    check("bubble", s_req, 0);
    txn(4'b1111, 1, 0, 0);
    txn(4'b1111, 2, 0, 0);
    txn(4'b1111, 3, 0, 0);
    repeat (3) begin @(negedge clk); s_ack = 0; #1; check("full_block", s_req, 0); end
    check("busy_full", busy, 1);
    resp(32'hA0);
    txn(4'b1111, 0, 1, 32'hA1);
    release_bus();
    resp(32'hA2);
    resp(32'hA3);
    resp(32'hA4);
    release_bus();
    check("busy_drained", busy, 0);
    // single write from master 2: one-cycle latency and payload passthrough
    @(negedge clk);
    m_req = 4'b0100; m_addr[64 +: 32] = 32'h4000_0010; m_wdata[64 +: 32] = 32'hDEADBEEF; m_cmd[2] = 1; #1;
    check("lat_t", s_req, 0);
    @(negedge clk); #1;
    check("lat_t1", s_req, 1);
    check("w_addr", s_addr, 32'h4000_0010);
    check("w_data", s_wdata, 32'hDEADBEEF);
    check("w_cmd", s_cmd, 1);
    s_ack = 1; #1;
    check("w_ack", m_ack, 4'b0100);
    exp_own.push_back(2);
    release_bus();
    resp(32'h5);
    // reads from 1,3,0 return in order
    m_cmd = 0;
    txn(4'b0010, 1, 0, 0);
    txn(4'b1000, 3, 0, 0);
    txn(4'b0001, 0, 0, 0);
    release_bus();
    resp(32'hA);
    resp(32'hB);
    resp(32'hC);
    // response with nothing outstanding
    resp(32'h77);
    @(negedge clk); s_resp = 0; #1;
    check("spurious_set", spurious_resp, 1);
    repeat (2) @(negedge clk);
    #1;
    check("spurious_sticky", spurious_resp, 1);
    // reset mid-request abandons outstanding IDs and restores master 0 priority
    txn(4'b1111, 1, 0, 0);
    @(negedge clk); s_ack = 0; #1;
    begin
      int n = 0;
      while (!s_req && n < 20) begin @(negedge clk); #1; n++; end
    end
    check("pre_rst_s_req", s_req, 1);
    s_ack = 1; #1;
    rst = 1; #1;
    check("arst_s_req", s_req, 0);
    check("arst_m_ack", m_ack, 0);
    check("arst_busy", busy, 0);
    check("arst_spurious", spurious_resp, 0);
    exp_own.delete();
    @(negedge clk); rst = 0; s_ack = 0;
    txn(4'b1111, 0, 0, 0);
    release_bus();
    resp(32'h99);
    resp(32'h98);
    @(negedge clk); s_resp = 0; #1;
    check("post_rst_spurious", spurious_resp, 1);
`ifdef XBAR_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      @(negedge clk); m_req = 4'b0001; s_ack = 0; s_resp = 0; #1;
      while (!s_req && n < 20) begin @(negedge clk); #1; n++; end
      n = 0;
      while (m_ack == 0 && n < 40) begin @(negedge clk); #1; n++; end
      check("tmo_cycles", n, 16);
      check("tmo_ack", m_ack, 4'b0001);
      check("tmo_err", m_err, 4'b0001);
      release_bus();
      check("tmo_busy", busy, 0);
    end
`endif
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", passed, total);
    $fatal(1, "watchdog");
  end
endmodule
